// File: rtl/mem_access_unit_if.sv
// Core-side request/response channel and word-wide memory port of the access unit.
// "master" drives the request (core) or the strobes (access unit); "slave" answers.
interface mau_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_error, resp_rdata
    );
endinterface

interface mau_mem_if;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_type;

    modport master (
        output mem_address, mem_wdata, mem_read, mem_write, mem_type,
        input  mem_rdata
    );
    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write, mem_type,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator for a word-wide ROM/RAM port.
// Sub-word stores are carried out as a read-modify-write of the containing word.
module mem_access_unit #(
    parameter logic [31:0] RAM_BASE     = 32'h0000_1000,
    parameter int          DEPTH_LOG2   = 5,
    parameter bit          ROM_WRITABLE = 1'b0,
    parameter logic        MEM_ROM      = 1'b0,
    parameter logic        MEM_RAM      = 1'b1
) (
    input  logic      clock,
    input  logic      reset_n,
    mau_req_if.slave  req,
    mau_mem_if.master mem
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_write, w_write_nxt;
    logic [2:0]  r_funct3, w_funct3_nxt;
    logic [1:0]  r_lane, w_lane_nxt;
    logic [15:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_mem_address, w_mem_address_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_mem_read, w_mem_read_nxt;
    logic        r_mem_write, w_mem_write_nxt;
    logic        r_mem_type, w_mem_type_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic        r_resp_error, w_resp_error_nxt;
    logic [31:0] r_resp_rdata, w_resp_rdata_nxt;

    logic        w_is_ram;
    logic [31:0] w_offset;
    logic [31:0] w_word;
    logic        w_range_err;
    logic        w_f3_err;
    logic        w_mis_err;
    logic        w_rom_err;
    logic        w_req_err;

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        res = word;
        case (funct3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h0, b};
            3'b101:  res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [15:0] wdata,
                                            input logic is_half, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        if (is_half) res[{lane[1], 4'b0000} +: 16] = wdata;
        else         res[{lane, 3'b000} +: 8]      = wdata[7:0];
        return res;
    endfunction

    // Request decode: region, word index within the region, and every error cause.
    assign w_is_ram    = (req.req_addr >= RAM_BASE);
    assign w_offset    = req.req_addr - (w_is_ram ? RAM_BASE : 32'd0);
    assign w_word      = w_offset >> 2;
    assign w_range_err = |(w_word >> DEPTH_LOG2);
    assign w_mis_err   = ((req.req_funct3[1:0] == 2'b01) && req.req_addr[0]) ||
                         ((req.req_funct3 == 3'b010) && (req.req_addr[1:0] != 2'b00));
    assign w_rom_err   = req.req_write && !w_is_ram && !ROM_WRITABLE;
    assign w_req_err   = w_range_err || w_f3_err || w_mis_err || w_rom_err;

    // Unsigned variants exist only for loads.
    always_comb begin
        w_f3_err = 1'b1;
        case (req.req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_err = 1'b0;
            3'b100, 3'b101:         w_f3_err = req.req_write;
            default:                w_f3_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_write_nxt       = r_write;
        w_funct3_nxt      = r_funct3;
        w_lane_nxt        = r_lane;
        w_wdata_nxt       = r_wdata;
        w_mem_address_nxt = r_mem_address;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_mem_type_nxt    = r_mem_type;
        w_mem_read_nxt    = 1'b0;
        w_mem_write_nxt   = 1'b0;
        w_resp_valid_nxt  = 1'b0;
        w_resp_error_nxt  = r_resp_error;
        w_resp_rdata_nxt  = r_resp_rdata;
        case (r_state)
            S_IDLE: begin
                if (req.req_valid) begin
                    w_write_nxt      = req.req_write;
                    w_funct3_nxt     = req.req_funct3;
                    w_lane_nxt       = req.req_addr[1:0];
                    w_wdata_nxt      = req.req_wdata[15:0];
                    w_resp_error_nxt = 1'b0;
                    w_resp_rdata_nxt = 32'h0;
                    if (w_req_err) begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_error_nxt = 1'b1;
                    end else begin
                        w_mem_address_nxt = w_word;
                        w_mem_type_nxt    = w_is_ram ? MEM_RAM : MEM_ROM;
                        if (req.req_write && (req.req_funct3 == 3'b010)) begin
                            w_state_nxt     = S_WRITE;
                            w_mem_write_nxt = 1'b1;
                            w_mem_wdata_nxt = req.req_wdata;
                        end else begin
                            w_state_nxt    = S_READ;
                            w_mem_read_nxt = 1'b1;
                        end
                    end
                end
            end
            S_READ: begin
                if (r_write) begin
                    w_state_nxt     = S_WRITE;
                    w_mem_write_nxt = 1'b1;
                    w_mem_wdata_nxt = f_merge(mem.mem_rdata, r_wdata, r_funct3[0], r_lane);
                end else begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = f_extract(mem.mem_rdata, r_funct3, r_lane);
                end
            end
            S_WRITE: begin
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
            end
            S_RESP: begin
                w_state_nxt      = S_IDLE;
                w_resp_error_nxt = 1'b0;
                w_resp_rdata_nxt = 32'h0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_mem_address <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_type    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_error  <= 1'b0;
            r_resp_rdata  <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_write       <= w_write_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_type    <= w_mem_type_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_resp_error  <= w_resp_error_nxt;
            r_resp_rdata  <= w_resp_rdata_nxt;
        end
    end

    // Request operands only matter after a accept, so they carry no reset.
    always_ff @(posedge clock) begin
        r_funct3 <= w_funct3_nxt;
        r_lane   <= w_lane_nxt;
        r_wdata  <= w_wdata_nxt;
    end

    assign req.req_ready   = (r_state == S_IDLE) && reset_n;
    assign req.resp_valid  = r_resp_valid;
    assign req.resp_error  = r_resp_error;
    assign req.resp_rdata  = r_resp_rdata;
    assign mem.mem_address = r_mem_address;
    assign mem.mem_wdata   = r_mem_wdata;
    assign mem.mem_read    = r_mem_read;
    assign mem.mem_write   = r_mem_write;
    assign mem.mem_type    = r_mem_type;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases, a mid-RMW reset, then random traffic
// checked against a byte-level reference model of the ROM/RAM contents.
module tb_mem_access_unit;
    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam int          WORDS    = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    mau_req_if req_if ();
    mau_mem_if mem_if ();

    mem_access_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_if),
        .mem     (mem_if)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [WORDS];
    logic [31:0] rom [WORDS];
    logic [31:0] init_ram [WORDS];
    logic [31:0] init_rom [WORDS];
    logic [31:0] ref_ram [WORDS];
    logic [31:0] ref_rom [WORDS];
    bit          preload   = 1'b0;
    int          rd_cnt    = 0;
    int          wr_cnt    = 0;
    int          both_cnt  = 0;
    int          resp_cnt  = 0;
    logic [31:0] last_addr = 32'h0;
    logic        last_type = 1'b0;
    int          checks    = 0;
    int          errors    = 0;

    // Memory: read data is combinational while mem_read is high, writes commit at the posedge.
    always_comb begin
        mem_if.mem_rdata = 32'h0;
        if (mem_if.mem_read)
            mem_if.mem_rdata = mem_if.mem_type ? ram[mem_if.mem_address[4:0]] : rom[mem_if.mem_address[4:0]];
    end

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) begin
                ram[i] <= init_ram[i];
                rom[i] <= init_rom[i];
            end
        end else if (mem_if.mem_write) begin
            if (mem_if.mem_type) ram[mem_if.mem_address[4:0]] <= mem_if.mem_wdata;
            else                 rom[mem_if.mem_address[4:0]] <= mem_if.mem_wdata;
        end
        if (mem_if.mem_read)  rd_cnt <= rd_cnt + 1;
        if (mem_if.mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_if.mem_read && mem_if.mem_write) both_cnt <= both_cnt + 1;
        if (mem_if.mem_read || mem_if.mem_write) begin
            last_addr <= mem_if.mem_address;
            last_type <= mem_if.mem_type;
        end
        if (req_if.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issues one request from a negedge, checks the response, returns at a negedge.
    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] obs_rdata);
        logic        is_ram, err, sgn, seen;
        logic [31:0] off, idx, word, val, mask, newword, exp_rdata;
        int          size, sh, lat, exp_lat, exp_rd, exp_wr, rd0, wr0;

        is_ram = (addr >= RAM_BASE);
        off    = is_ram ? addr - RAM_BASE : addr;
        idx    = off / 4;
        sh     = 8 * int'(off % 4);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        sgn = (f3 == 3'd0) || (f3 == 3'd1);
        err = (size == 0) || (wr && f3 > 3'd2) || (idx >= WORDS) || (wr && !is_ram);
        if (size != 0 && (int'(off % 4) % size) != 0) err = 1'b1;
        word = (idx < WORDS) ? (is_ram ? ref_ram[idx[4:0]] : ref_rom[idx[4:0]]) : 32'h0;

        exp_rdata = 32'h0; exp_rd = 0; exp_wr = 0; exp_lat = 1; newword = word;
        if (!err) begin
            if (!wr) begin
                exp_lat = 2; exp_rd = 1;
                val = word >> sh;
                if (size == 1) begin
                    val = val & 32'hFF;
                    if (sgn && val >= 32'h80) val = val | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    val = val & 32'hFFFF;
                    if (sgn && val >= 32'h8000) val = val | 32'hFFFF_0000;
                end
                exp_rdata = val;
            end else if (size == 4) begin
                exp_lat = 2; exp_wr = 1; newword = wd;
            end else begin
                exp_lat = 3; exp_rd = 1; exp_wr = 1;
                mask    = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
                newword = (word & ~mask) | ((wd << sh) & mask);
            end
        end

        lat = 0;
        while (req_if.req_ready !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_ready"}, {31'b0, req_if.req_ready}, 32'h1);

        req_if.req_valid  = 1'b1;
        req_if.req_write  = wr;
        req_if.req_funct3 = f3;
        req_if.req_addr   = addr;
        req_if.req_wdata  = wd;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clock);
        #1 req_if.req_valid = 1'b0;

        lat = 0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clock);
            lat++;
            if (req_if.resp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) lat = 99;
        obs_rdata = req_if.resp_rdata;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_error"}, {31'b0, req_if.resp_error}, {31'b0, err});
        check({tag, "_rdata"}, req_if.resp_rdata, exp_rdata);

        @(negedge clock);
        check({tag, "_pulse"}, {31'b0, req_if.resp_valid}, 32'h0);
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_rd + exp_wr > 0) begin
            check({tag, "_addr"}, last_addr, idx);
            check({tag, "_type"}, {31'b0, last_type}, {31'b0, is_ram});
        end
        if (!err && wr) begin
            if (is_ram) ref_ram[idx[4:0]] = newword;
            else        ref_rom[idx[4:0]] = newword;
        end
        if (idx < WORDS)
            check({tag, "_mem"}, is_ram ? ram[idx[4:0]] : rom[idx[4:0]],
                  is_ram ? ref_ram[idx[4:0]] : ref_rom[idx[4:0]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  f;
        logic        w;
        int          rw, ra, rt;

        req_if.req_valid  = 1'b0;
        req_if.req_write  = 1'b0;
        req_if.req_funct3 = 3'd0;
        req_if.req_addr   = 32'h0;
        req_if.req_wdata  = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            init_ram[i] = $urandom;
            init_rom[i] = $urandom;
        end
        init_ram[2] = 32'hDEAD_BEEF;
        preload = 1'b1;
        @(posedge clock);
        #1 preload = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            ref_ram[i] = init_ram[i];
            ref_rom[i] = init_rom[i];
        end

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_ready", {31'b0, req_if.req_ready}, 32'h0);
        check("rst_resp_valid", {31'b0, req_if.resp_valid}, 32'h0);
        check("rst_resp_rdata", req_if.resp_rdata, 32'h0);
        check("rst_mem_read", {31'b0, mem_if.mem_read}, 32'h0);
        check("rst_mem_write", {31'b0, mem_if.mem_write}, 32'h0);
        check("rst_mem_address", mem_if.mem_address, 32'h0);
        check("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
        check("rst_mem_type", {31'b0, mem_if.mem_type}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready_after", {31'b0, req_if.req_ready}, 32'h1);

        // Directed cases.
        do_req("lw_1008", 1'b0, 3'd2, 32'h1008, 32'h0, rd);
        check("lw_1008_value", rd, 32'hDEAD_BEEF);
        do_req("lb_1009", 1'b0, 3'd0, 32'h1009, 32'h0, rd);
        check("lb_1009_value", rd, 32'hFFFF_FFBE);
        do_req("lbu_1009", 1'b0, 3'd4, 32'h1009, 32'h0, rd);
        check("lbu_1009_value", rd, 32'h0000_00BE);
        do_req("sb_100a", 1'b1, 3'd0, 32'h100A, 32'h55, rd);
        check("sb_100a_word", ram[2], 32'hDE55_BEEF);
        do_req("lh_1001", 1'b0, 3'd1, 32'h1001, 32'h0, rd);
        do_req("sw_rom", 1'b1, 3'd2, 32'h0004, 32'h1234_5678, rd);
        do_req("lw_last", 1'b0, 3'd2, 32'h107C, 32'h0, rd);
        do_req("lw_oor_ram", 1'b0, 3'd2, 32'h1080, 32'h0, rd);
        do_req("lw_rom_last", 1'b0, 3'd2, 32'h007C, 32'h0, rd);
        do_req("lw_oor_rom", 1'b0, 3'd2, 32'h0080, 32'h0, rd);
        do_req("bad_f3", 1'b0, 3'd3, 32'h1000, 32'h0, rd);
        do_req("sh_hi", 1'b1, 3'd1, 32'h1012, 32'hCAFE_8001, rd);
        do_req("lhu_hi", 1'b0, 3'd5, 32'h1012, 32'h0, rd);
        do_req("lh_hi", 1'b0, 3'd1, 32'h1012, 32'h0, rd);
        do_req("sw_ram", 1'b1, 3'd2, 32'h1014, 32'h8765_4321, rd);

        // Reset while an SH is in its write cycle.
        rw = resp_cnt;
        ra = wr_cnt;
        req_if.req_valid  = 1'b1;
        req_if.req_write  = 1'b1;
        req_if.req_funct3 = 3'd1;
        req_if.req_addr   = 32'h1010;
        req_if.req_wdata  = 32'h0000_A5A5;
        @(posedge clock);
        #1 req_if.req_valid = 1'b0;
        @(negedge clock);
        check("mid_rst_read", {31'b0, mem_if.mem_read}, 32'h1);
        @(negedge clock);
        check("mid_rst_write_before", {31'b0, mem_if.mem_write}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_write_drop", {31'b0, mem_if.mem_write}, 32'h0);
        check("mid_rst_ready_low", {31'b0, req_if.req_ready}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_ready_after", {31'b0, req_if.req_ready}, 32'h1);
        check("mid_rst_mem", ram[4], ref_ram[4]);
        check("mid_rst_no_commit", 32'(wr_cnt - ra), 32'h0);
        check("mid_rst_no_resp", 32'(resp_cnt - rw), 32'h0);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            w  = ($urandom_range(0, 2) == 0);
            rt = $urandom_range(0, 9);
            if (w) f = 3'($urandom_range(0, 2));
            else if (rt < 8) f = (rt < 2) ? 3'd0 : (rt < 4) ? 3'd1 : (rt < 6) ? 3'd2 : (rt < 7) ? 3'd4 : 3'd5;
            else f = (rt == 8) ? 3'd3 : 3'd6;
            a = ($urandom_range(0, 3) == 0) ? 32'h0 : RAM_BASE;
            a = a + 32'($urandom_range(0, 33)) * 4;
            if ($urandom_range(0, 1) == 1) a = a + 32'($urandom_range(0, 3));
            do_req($sformatf("rnd%0d", n), w, f, a, $urandom, rd);
        end

        check("strobe_overlap", 32'(both_cnt), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
